// File: rtl/dct_block_feeder_if.sv
// Pixel stream into the block feeder and framed row stream toward the DCT array.
interface dct_block_feeder_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_sop;
  logic                  m_eop;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, m_valid, m_data, m_sop, m_eop
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, m_valid, m_data, m_sop, m_eop
  );
endinterface

// File: rtl/dct_block_feeder.sv
// Ping-pong buffer that collects raster-order 8x8 blocks and replays them to the
// DCT array as framed row bursts with a programmable idle gap after every row.
module dct_block_feeder #(
  parameter int DATA_WIDTH = 10,
  parameter int N          = 8,
  parameter int ROW_GAP    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  dct_block_feeder_if.slave bus,
  output logic              busy,
  output logic              err_len
);
  localparam int BLK      = N * N;
  localparam int IDX_W    = $clog2(BLK);
  localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam int MEM_W    = $clog2(2 * BLK);
  localparam int GAP_LAST = (ROW_GAP > 0) ? ROW_GAP - 1 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    GAP  = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [2*BLK];

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            full_q, full_d;
  logic [CNT_W-1:0]      row_q, row_d;
  logic [CNT_W-1:0]      col_q, col_d;
  logic [3:0]            gap_q, gap_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_sop_q, m_sop_d;
  logic                  m_eop_q, m_eop_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

  logic                  accept_s;
  logic                  blk_end_s;
  logic                  emit_s;
  logic                  release_s;
  logic [MEM_W-1:0]      wr_addr_s;
  logic [MEM_W-1:0]      rd_addr_s;

  assign bus.s_ready = !full_q[wr_bank_q];
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_sop   = m_sop_q;
  assign bus.m_eop   = m_eop_q;
  assign busy        = busy_q;
  assign err_len     = err_q;

  // Write side: index/bank advance and framing-error detection.
  always_comb begin
    accept_s  = bus.s_valid && !full_q[wr_bank_q];
    blk_end_s = accept_s && (wr_idx_q == IDX_W'(BLK - 1));
    wr_addr_s = MEM_W'(int'(wr_bank_q) * BLK + int'(wr_idx_q));
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    err_d     = err_q;
    if (blk_end_s) begin
      wr_idx_d  = '0;
      wr_bank_d = !wr_bank_q;
      err_d     = err_q | !bus.s_last;
    end else if (accept_s && bus.s_last) begin
      // Early s_last: the partial block is dropped, its bank stays free.
      wr_idx_d = '0;
      err_d    = 1'b1;
    end else if (accept_s) begin
      wr_idx_d = wr_idx_q + 1'b1;
    end else begin
      wr_idx_d = wr_idx_q;
    end
  end

  // Read FSM: row/column walk, row gaps and bank release.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    gap_d     = gap_q;
    rd_bank_d = rd_bank_q;
    emit_s    = 1'b0;
    release_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          emit_s  = 1'b1;
          state_d = ROW;
        end else begin
          state_d = IDLE;
        end
      end
      ROW: begin
        emit_s = 1'b1;
      end
      GAP: begin
        if (gap_q == 4'(GAP_LAST)) begin
          gap_d = 4'd0;
          if (row_q == CNT_W'(N - 1)) begin
            release_s = 1'b1;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ROW;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (emit_s && (col_q != CNT_W'(N - 1))) begin
      col_d   = col_q + 1'b1;
      state_d = ROW;
    end else if (emit_s) begin
      col_d = '0;
      if (ROW_GAP > 0) begin
        state_d = GAP;
        gap_d   = 4'd0;
      end else if (row_q != CNT_W'(N - 1)) begin
        row_d   = row_q + 1'b1;
        state_d = ROW;
      end else begin
        release_s = 1'b1;
      end
    end else begin
      col_d = col_q;
    end

    // Chain straight into the other bank when it is already waiting.
    if (release_s) begin
      rd_bank_d = !rd_bank_q;
      row_d     = '0;
      col_d     = '0;
      state_d   = full_q[!rd_bank_q] ? ROW : IDLE;
    end else begin
      rd_bank_d = rd_bank_q;
    end
  end

  // Full flags and registered output stage.
  always_comb begin
    full_d = full_q;
    if (release_s) begin
      full_d[rd_bank_q] = 1'b0;
    end else begin
      full_d[rd_bank_q] = full_q[rd_bank_q];
    end
    if (blk_end_s) begin
      full_d[wr_bank_q] = 1'b1;
    end else begin
      full_d[wr_bank_q] = full_d[wr_bank_q];
    end
    rd_addr_s = MEM_W'(int'(rd_bank_q) * BLK + int'(row_q) * N + int'(col_q));
    m_valid_d = emit_s;
    m_sop_d   = emit_s && (row_q == '0) && (col_q == '0);
    m_eop_d   = emit_s && (row_q == CNT_W'(N - 1)) && (col_q == CNT_W'(N - 1));
    if (emit_s) begin
      m_data_d = mem_q[rd_addr_s];
    end else begin
      m_data_d = m_data_q;
    end
    busy_d = (full_q != 2'b00) || (state_q != IDLE);
  end

  // Sample storage, deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_addr_s] <= bus.s_data;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      row_q     <= '0;
      col_q     <= '0;
      gap_q     <= 4'd0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_sop_q   <= 1'b0;
      m_eop_q   <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      row_q     <= row_d;
      col_q     <= col_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      m_valid_q <= m_valid_d;
      m_sop_q   <= m_sop_d;
      m_eop_q   <= m_eop_d;
      m_data_q  <= m_data_d;
    end
  end
endmodule
